wb_cmd_master: RTL

- Wishbone initiator that turns a simple command stream into single classic Wishbone read/write cycles.
- It returns one response per command.
- It drives the project harness wishbone slave (project select, ws2812, 7seg, asic_freq registers) from the logic analyzer, a test controller or a future UART bridge.
- It adds an ack timeout so an unmapped address cannot hang the bus, plus a saturating error counter.

---
 rtl/wb_cmd_master_if.sv | 47 ++++
 rtl/wb_cmd_master.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master_if
// Brief    : Command/response stream plus classic Wishbone master bus bundle.
// Revision : 1.0
// ============================================================================
interface wb_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat,
        output cmd_ready,
        output rsp_valid, rsp_dat, rsp_err,
        input  rsp_ready,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_sel, cmd_adr, cmd_dat,
        input  cmd_ready,
        input  rsp_valid, rsp_dat, rsp_err,
        output rsp_ready,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Brief    : Turns a command stream into single classic Wishbone cycles, one
//            response per command, with ack timeout and saturating error count.
// Revision : 1.0
// ============================================================================
module wb_cmd_master #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERR_CNT_W      = 16
) (
    input  wire                  wb_clk_i,
    input  wire                  wb_rst_i,
    wb_cmd_master_if.master      bus,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_BUS      = 2'd1;
    localparam logic [1:0]  c_RESP     = 2'd2;
    localparam logic [15:0] c_TMR_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] c_ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [15:0]          tmr_q, tmr_d;
    logic                 cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_dat_q, rsp_dat_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic w_accept;
    logic w_timeout;

    // A registered-ack slave may still hold ack for a cycle after cyc drops;
    // refusing commands while it is high keeps that stale ack from closing
    // the next cycle.
    always_comb begin
        bus.cmd_ready = (state_q == c_IDLE) & ~bus.wbm_ack_i & ~wb_rst_i;
    end

    assign w_accept  = bus.cmd_valid & bus.cmd_ready;
    assign w_timeout = ~bus.wbm_ack_i & (tmr_q == c_TMR_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_accept) state_d = c_BUS;
            c_BUS:   if (bus.wbm_ack_i || w_timeout) state_d = c_RESP;
            c_RESP:  if (bus.rsp_ready) state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        tmr_d       = tmr_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        err_d       = err_q;
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    we_d  = bus.cmd_we;
                    sel_d = bus.cmd_sel;
                    adr_d = bus.cmd_adr;
                    dat_d = bus.cmd_dat;
                    cyc_d = 1'b1;
                    tmr_d = 16'd0;
                end
            end
            c_BUS: begin
                if (bus.wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? 32'd0 : bus.wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (w_timeout) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = 32'd0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (~&err_q) begin
                        err_d = err_q + c_ERR_ONE;
                    end
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            c_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmr_q       <= 16'd0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'd0;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'd0;
            rsp_err_q   <= 1'b0;
            err_q       <= '0;
        end else begin
            tmr_q       <= tmr_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            err_q       <= err_d;
        end
    end

    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_adr_o = adr_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign err_count     = err_q;

endmodule
`default_nettype wire
